// File: rtl/io_mcp23017_target.sv
// I2C target exposing the MCP23017 register protocol: address match, register pointer,
// auto-incrementing writes (strobed out) and reads (fetched through rd_addr/rd_data).
module io_mcp23017_target #(
   parameter logic [3:0] ADDR_HI  = 4'b0100,
   parameter int         NUM_REGS = 22
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] hardware_address,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

   // Write interface: wr_strobe is a single-cycle pulse with no back-pressure; wr_addr and
   // wr_data are valid in that cycle. rd_addr doubles as the register pointer.
   localparam logic [7:0] LAST_REG = 8'(NUM_REGS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
   } state_t;

   state_t     state;
   logic       scl_meta, scl_s, scl_q;
   logic       sda_meta, sda_s, sda_q;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       rw;
   logic       ack_on;
   logic       load_pend;

   logic       scl_rise, scl_fall, start_c, stop_c;
   logic [7:0] sh_next, ptr_inc;

   assign scl_rise = scl_s & ~scl_q;
   assign scl_fall = ~scl_s & scl_q;
   assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;
   assign sh_next  = {shreg[6:0], sda_s};
   assign ptr_inc  = (rd_addr == LAST_REG) ? 8'd0 : rd_addr + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Synchronisers reset to the idle-bus level so release cannot fake an edge.
         scl_meta  <= 1'b1;
         scl_s     <= 1'b1;
         scl_q     <= 1'b1;
         sda_meta  <= 1'b1;
         sda_s     <= 1'b1;
         sda_q     <= 1'b1;
         state     <= S_IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 8'd0;
         rw        <= 1'b0;
         ack_on    <= 1'b0;
         load_pend <= 1'b0;
         sda_oe    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= 8'd0;
         wr_data   <= 8'd0;
         rd_addr   <= 8'd0;
         busy      <= 1'b0;
      end else begin
         scl_meta  <= scl;
         scl_s     <= scl_meta;
         scl_q     <= scl_s;
         sda_meta  <= sda_in;
         sda_s     <= sda_meta;
         sda_q     <= sda_s;
         wr_strobe <= 1'b0;
         if (start_c) begin
            state   <= S_ADDR;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b0;
            ack_on  <= 1'b0;
         end else if (stop_c) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
            ack_on <= 1'b0;
         end else begin
            case (state)
               S_ADDR: if (scl_rise) begin
                  shreg   <= sh_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (sh_next[7:1] == {ADDR_HI, hardware_address}) begin
                        state <= S_ADDR_ACK;
                        rw    <= sh_next[0];
                        busy  <= 1'b1;
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
               end
               // ACK phases: first SCL fall pulls SDA, second fall releases and moves on.
               S_ADDR_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     ack_on <= 1'b1;
                     sda_oe <= 1'b1;
                  end else begin
                     ack_on  <= 1'b0;
                     bit_cnt <= 3'd0;
                     if (rw) begin
                        shreg     <= rd_data;
                        sda_oe    <= ~rd_data[7];
                        load_pend <= 1'b0;
                        state     <= S_RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= S_REG;
                     end
                  end
               end
               S_REG: if (scl_rise) begin
                  shreg   <= sh_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (sh_next <= LAST_REG) begin
                        rd_addr <= sh_next;
                        state   <= S_REG_ACK;
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
               end
               S_REG_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     ack_on <= 1'b1;
                     sda_oe <= 1'b1;
                  end else begin
                     ack_on  <= 1'b0;
                     sda_oe  <= 1'b0;
                     bit_cnt <= 3'd0;
                     state   <= S_WDATA;
                  end
               end
               S_WDATA: if (scl_rise) begin
                  shreg   <= sh_next;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     wr_strobe <= 1'b1;
                     wr_addr   <= rd_addr;
                     wr_data   <= sh_next;
                     state     <= S_WDATA_ACK;
                  end
               end
               S_WDATA_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     ack_on <= 1'b1;
                     sda_oe <= 1'b1;
                  end else begin
                     ack_on  <= 1'b0;
                     sda_oe  <= 1'b0;
                     bit_cnt <= 3'd0;
                     rd_addr <= ptr_inc;
                     state   <= S_WDATA;
                  end
               end
               // A pending load happens on the fall that ends the master's ACK bit.
               S_RDATA: if (scl_fall) begin
                  if (load_pend) begin
                     shreg     <= rd_data;
                     sda_oe    <= ~rd_data[7];
                     load_pend <= 1'b0;
                     bit_cnt   <= 3'd0;
                  end else if (bit_cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     state  <= S_RACK;
                  end else begin
                     shreg   <= {shreg[6:0], 1'b0};
                     sda_oe  <= ~shreg[6];
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               S_RACK: if (scl_rise) begin
                  if (!sda_s) begin
                     rd_addr   <= ptr_inc;
                     load_pend <= 1'b1;
                     state     <= S_RDATA;
                  end else begin
                     state <= S_IGNORE;
                  end
               end
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_io_mcp23017_target.sv
// Bench for io_mcp23017_target: bus-level I2C master, register file model and write scoreboard.
module tb_io_mcp23017_target;

   localparam int Q = 60;
   localparam int H = 20;
   localparam int NREG = 22;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] hw = 3'd0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe, wr_strobe, busy;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
   wire        sda_line = sda_m & ~sda_oe;

   logic [7:0]  regfile [0:31];
   logic        pl_we = 1'b0;
   logic [4:0]  pl_addr = 5'd0;
   logic [7:0]  pl_data = 8'd0;

   logic [7:0]  mmem [0:NREG-1];
   int          mptr = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  tx_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   io_mcp23017_target dut (
      .clk(clk), .rst_n(rst_n), .hardware_address(hw), .scl(scl), .sda_in(sda_line),
      .sda_oe(sda_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   assign rd_data = (rd_addr < 8'(NREG)) ? regfile[rd_addr[4:0]] : 8'h00;

   always @(posedge clk) begin
      if (wr_strobe) regfile[wr_addr[4:0]] <= wr_data;
      else if (pl_we) regfile[pl_addr] <= pl_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) begin
         check_eq("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check_eq("strobe_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
      end
   end

   always @(sda_oe) begin
      if (rst_n === 1'b1) check_eq("oe_edge_scl_low", 32'(scl), 32'd0);
   end

   task automatic preload(input int a, input logic [7:0] d);
      pl_addr = 5'(a);
      pl_data = d;
      pl_we   = 1'b1;
      @(posedge clk);
      #2;
      pl_we   = 1'b0;
      mmem[a] = d;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q;
      scl = 1'b1;   #Q;
      sda_m = 1'b0; #Q;
      scl = 1'b0;   #H;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q;
      scl = 1'b1;   #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic i2c_wbyte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; #Q;
         scl = 1'b1;   #(2*Q);
         scl = 1'b0;   #H;
      end
      sda_m = 1'b1; #Q;
      scl = 1'b1;   #Q;
      ack = sda_line; #Q;
      scl = 1'b0;   #H;
   endtask

   task automatic i2c_rbyte(output logic [7:0] b, input logic nack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; #Q;
         scl = 1'b1;   #Q;
         b[i] = sda_line; #Q;
         scl = 1'b0;   #H;
      end
      sda_m = nack; #Q;
      scl = 1'b1;   #(2*Q);
      scl = 1'b0;   #H;
      sda_m = 1'b1;
   endtask

   // Write transaction: address, pointer byte, then the bytes queued in tx_q.
   task automatic wr_xfer(input logic [6:0] dev, input logic [7:0] pbyte);
      logic ack;
      bit   ok;
      i2c_start();
      i2c_wbyte({dev, 1'b0}, ack);
      ok = (dev == {4'b0100, hw});
      check_eq("addr_ack", 32'(ack), 32'(!ok));
      check_eq("busy_after_addr", 32'(busy), 32'(ok));
      i2c_wbyte(pbyte, ack);
      ok = ok && (int'(pbyte) < NREG);
      check_eq("ptr_ack", 32'(ack), 32'(!ok));
      if (ok) mptr = int'(pbyte);
      foreach (tx_q[i]) begin
         if (ok) begin
            exp_q.push_back({8'(mptr), tx_q[i]});
            mmem[mptr] = tx_q[i];
            mptr = (mptr + 1) % NREG;
         end
         i2c_wbyte(tx_q[i], ack);
         check_eq("data_ack", 32'(ack), 32'(!ok));
      end
      tx_q.delete();
      i2c_stop();
      #Q;
      check_eq("busy_after_stop", 32'(busy), 32'd0);
      check_eq("strobes_done", exp_q.size(), 32'd0);
      check_eq("rd_addr_ptr", 32'(rd_addr), 32'(mptr));
   endtask

   // Pointer write, repeated START, then nrd reads (master ACKs all but the last).
   task automatic rd_xfer(input logic [7:0] pbyte, input int nrd);
      logic       ack;
      logic [7:0] b;
      logic [6:0] dev;
      dev = {4'b0100, hw};
      i2c_start();
      i2c_wbyte({dev, 1'b0}, ack);
      check_eq("rd_addr_ack", 32'(ack), 32'd0);
      i2c_wbyte(pbyte, ack);
      check_eq("rd_ptr_ack", 32'(ack), 32'd0);
      mptr = int'(pbyte);
      i2c_start();
      i2c_wbyte({dev, 1'b1}, ack);
      check_eq("rd_dev_ack", 32'(ack), 32'd0);
      for (int i = 0; i < nrd; i++) begin
         check_eq("rd_addr_before_byte", 32'(rd_addr), 32'(mptr));
         i2c_rbyte(b, (i == nrd - 1));
         check_eq("rd_byte", 32'(b), 32'(mmem[mptr]));
         if (i != nrd - 1) mptr = (mptr + 1) % NREG;
      end
      check_eq("oe_after_nack", 32'(sda_oe), 32'd0);
      i2c_stop();
      #Q;
      check_eq("rd_busy_after_stop", 32'(busy), 32'd0);
      check_eq("rd_addr_after", 32'(rd_addr), 32'(mptr));
   endtask

   initial begin
      logic       ack;
      logic [6:0] dev;
      int         op;
      #2;
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
      check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
      check_eq("rst_wr_data", 32'(wr_data), 32'd0);
      check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < NREG; i++) preload(i, 8'($urandom_range(0, 255)));

      hw = 3'd0;
      tx_q = '{8'hA5};
      wr_xfer(7'h20, 8'h12);

      tx_q = '{8'h77};
      wr_xfer(7'h21, 8'h03);

      hw = 3'd5;
      tx_q = '{8'h11, 8'h22, 8'h33};
      wr_xfer(7'h25, 8'h14);

      hw = 3'd0;
      preload(9, 8'h3C);
      preload(10, 8'hC3);
      rd_xfer(8'h09, 2);

      tx_q = '{8'h55, 8'h66};
      wr_xfer(7'h20, 8'h16);

      for (int it = 0; it < 20; it++) begin
         hw = 3'($urandom_range(0, 7));
         op = $urandom_range(0, 2);
         if (op < 2) begin
            dev = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : {4'b0100, hw};
            for (int k = $urandom_range(0, 3); k > 0; k--) tx_q.push_back(8'($urandom_range(0, 255)));
            wr_xfer(dev, 8'($urandom_range(0, 25)));
         end else begin
            rd_xfer(8'($urandom_range(0, NREG - 1)), $urandom_range(1, 3));
         end
      end

      hw = 3'd0;
      preload(3, 8'h00);
      i2c_start();
      i2c_wbyte(8'h40, ack);
      i2c_wbyte(8'h03, ack);
      i2c_start();
      i2c_wbyte(8'h41, ack);
      check_eq("mid_rd_dev_ack", 32'(ack), 32'd0);
      sda_m = 1'b1; #Q;
      scl = 1'b1;   #Q;
      check_eq("mid_oe_driving", 32'(sda_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
      check_eq("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      check_eq("mid_rst_wr_data", 32'(wr_data), 32'd0);
      check_eq("mid_rst_wr_strobe", 32'(wr_strobe), 32'd0);
      #(Q - 1);
      rst_n = 1'b1;
      mptr = 0;
      #Q;
      tx_q = '{8'h5A};
      wr_xfer(7'h20, 8'h04);
      rd_xfer(8'h04, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
